// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state type and width helpers for the iterative square root
package sqrt_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   function automatic int root_w(input int w);
      return w / 2;
   endfunction
   function automatic int rem_w(input int w);
      return w / 2 + 1;
   endfunction
   function automatic bit width_ok(input int w);
      return w >= 4 && w % 2 == 0;
   endfunction
endpackage

// File: rtl/sqrt_iter_pipe_if.sv
// sqrt_iter_pipe_if: radicand in / root+remainder out valid-ready bundle
interface sqrt_iter_pipe_if import sqrt_pkg::*; #(parameter int WIDTH = 16);
   localparam int RW = root_w(WIDTH);
   localparam int REMW = rem_w(WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [RW-1:0]    out_root;
   logic [REMW-1:0]  out_rem;
   logic             busy;
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_root, out_rem, busy);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_root, out_rem, busy);
endinterface

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational non-restoring square-root iteration
module sqrt_step #(parameter int RW = 8) (
   input  logic [RW-1:0] q,
   input  logic [RW+1:0] r,
   input  logic [1:0]    pair,
   output logic [RW-1:0] q_n,
   output logic [RW+1:0] r_n
);
   // r is two's complement; the top two bits of {r,pair} are dropped since the result always fits
   assign r_n = r[RW+1] ? (RW+2)'({r, pair} + (RW+4)'({q, 2'b11}))
                        : (RW+2)'({r, pair} - (RW+4)'({q, 2'b01}));
   assign q_n = RW'({q, ~r_n[RW+1]});
endmodule

// File: rtl/sqrt_iter_pipe.sv
// sqrt_iter_pipe: sequential floor(sqrt(x)) and remainder, one root bit per clock
module sqrt_iter_pipe import sqrt_pkg::*; #(parameter int WIDTH = 16) (
   input logic clk,
   input logic rst_n,
   sqrt_iter_pipe_if.slave s
);
   localparam int RW = root_w(WIDTH);
   localparam int REMW = rem_w(WIDTH);
   localparam int CW = $clog2(RW);
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("sqrt_iter_pipe: WIDTH must be even and >= 4");
   end
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] sr;
   logic [RW-1:0] q, q_n;
   logic [RW+1:0] r, r_n, r_fix;
   logic last;
   sqrt_step #(.RW(RW)) u_step (.q, .r, .pair(sr[WIDTH-1 -: 2]), .q_n, .r_n);
   assign last = cnt == CW'(RW - 1);
   assign r_fix = r[RW+1] ? r + {1'b0, q, 1'b1} : r;
   assign s.in_ready = state == IDLE;
   assign s.out_valid = state == DONE;
   assign s.busy = state == CALC || state == FIX;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: state_n = s.in_valid ? CALC : IDLE;
         CALC: state_n = last ? FIX : CALC;
         FIX:  state_n = DONE;
         DONE: state_n = s.out_ready ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
         q <= '0;
         r <= '0;
         cnt <= '0;
         s.out_root <= '0;
         s.out_rem <= '0;
      end else begin
         unique case (state)
            IDLE: if (s.in_valid) begin
               sr <= s.in_data;
               q <= '0;
               r <= '0;
               cnt <= '0;
            end
            CALC: begin
               sr <= sr << 2;
               q <= q_n;
               r <= r_n;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               s.out_root <= q;
               s.out_rem <= REMW'(r_fix);
            end
            DONE: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sqrt_iter_pipe.sv
// tb_sqrt_iter_pipe: directed checks of the 16-bit root plus an exhaustive 8-bit sweep
module tb_sqrt_iter_pipe;
   logic clk = 0;
   logic rst_n = 0;
   int errs = 0;
   int checks = 0;
   always #5 clk = ~clk;
   sqrt_iter_pipe_if #(.WIDTH(16)) b16 ();
   sqrt_iter_pipe_if #(.WIDTH(8)) b8 ();
   sqrt_iter_pipe #(.WIDTH(16)) d16 (.clk(clk), .rst_n(rst_n), .s(b16.slave));
   sqrt_iter_pipe #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .s(b8.slave));
   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send16(input int x);
      b16.in_valid = 1;
      b16.in_data = 16'(x);
      step();
      b16.in_valid = 0;
   endtask
   task automatic wait16(output int k);
      k = 0;
      while (!b16.out_valid && k < 40) begin
         step();
         k++;
      end
   endtask
   task automatic pop16();
      b16.out_ready = 1;
      step();
      b16.out_ready = 0;
   endtask
   task automatic calc16(input int x, input int er, input int em, input string tag);
      int k;
      check({tag, " in_ready"}, b16.in_ready, 1);
      send16(x);
      wait16(k);
      check({tag, " latency"}, k, 9);
      check({tag, " root"}, b16.out_root, er);
      check({tag, " rem"}, b16.out_rem, em);
      check({tag, " busy"}, b16.busy, 0);
      pop16();
      check({tag, " valid drop"}, b16.out_valid, 0);
      check({tag, " idle"}, b16.in_ready, 1);
   endtask
   int vv[6] = '{1, 2, 3, 99, 65025, 65024};
   int vr[6] = '{1, 1, 1, 9, 255, 254};
   int vm[6] = '{0, 1, 2, 18, 0, 508};
   initial begin
      int k, ai, ri, cyc, n8, er8;
      logic acc, got, pv;
      b16.in_valid = 0; b16.in_data = '0; b16.out_ready = 0;
      b8.in_valid = 0; b8.in_data = '0; b8.out_ready = 0;
      repeat (3) step();
      rst_n = 1;
      step();
      check("rst in_ready", b16.in_ready, 1);
      check("rst out_valid", b16.out_valid, 0);
      check("rst busy", b16.busy, 0);
      check("rst root", b16.out_root, 0);
      check("rst rem", b16.out_rem, 0);
      calc16(144, 12, 0, "x144");
      calc16(0, 0, 0, "x0");
      calc16(65535, 255, 510, "xmax");
      send16(1000);
      wait16(k);
      check("bp latency", k, 9);
      for (int i = 0; i < 20; i++) begin
         check("bp valid", b16.out_valid, 1);
         check("bp root", b16.out_root, 31);
         check("bp rem", b16.out_rem, 39);
         check("bp in_ready", b16.in_ready, 0);
         step();
      end
      pop16();
      send16(50000);
      step();
      step();
      check("mid busy", b16.busy, 1);
      rst_n = 0;
      #1;
      check("mid rst busy", b16.busy, 0);
      check("mid rst valid", b16.out_valid, 0);
      check("mid rst root", b16.out_root, 0);
      check("mid rst rem", b16.out_rem, 0);
      step();
      rst_n = 1;
      step();
      check("post rst in_ready", b16.in_ready, 1);
      check("post rst valid", b16.out_valid, 0);
      calc16(200, 14, 4, "x200");
      ai = 0; ri = 0; cyc = 0;
      b16.out_ready = 1;
      b16.in_valid = 1;
      b16.in_data = 16'(vv[0]);
      while (ri < 6 && cyc < 200) begin
         acc = b16.in_ready && b16.in_valid;
         got = b16.out_valid;
         step();
         cyc++;
         if (acc) begin
            ai++;
            if (ai < 6) b16.in_data = 16'(vv[ai]);
            else b16.in_valid = 0;
         end
         if (got) begin
            check("b2b root", b16.out_root, vr[ri]);
            check("b2b rem", b16.out_rem, vm[ri]);
            ri++;
         end
      end
      check("b2b count", ri, 6);
      check("b2b accepts", ai, 6);
      b16.in_valid = 0;
      b16.out_ready = 0;
      step();
      n8 = 0;
      for (int x = 0; x < 256; x++) begin
         er8 = 0;
         while ((er8 + 1) * (er8 + 1) <= x) er8++;
         k = 0;
         while (!b8.in_ready && k < 50) begin
            step();
            k++;
         end
         b8.in_valid = 1;
         b8.in_data = 8'(x);
         step();
         b8.in_valid = 0;
         k = 0;
         got = 0;
         while (!got && k < 100) begin
            b8.out_ready = 1'($urandom_range(0, 1));
            pv = b8.out_valid;
            step();
            k++;
            if (pv && b8.out_ready) begin
               got = 1;
               n8++;
               check("w8 root", b8.out_root, er8);
               check("w8 rem", b8.out_rem, x - er8 * er8);
            end
         end
         b8.out_ready = 0;
         check("w8 got", got, 1);
         check("w8 no dup", b8.out_valid, 0);
      end
      check("w8 count", n8, 256);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
